// File: rtl/uart_tx_param_if.sv
`timescale 1ns/1ps
// Host-to-transmitter bundle: write strobe, word, frame config, serial line and FIFO status.
// master = host side, slave = uart_tx_param.
interface uart_tx_param_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  tx_start;
    logic [DATA_WIDTH-1:0] tx_data_in;
    logic [1:0]            parity_mode;
    logic                  stop2;
    logic                  tx_data_out;
    logic                  tx_busy;
    logic                  tx_full;
    logic                  tx_empty;
    logic                  tx_overflow;

    modport master (
        output tx_start, tx_data_in, parity_mode, stop2,
        input  tx_data_out, tx_busy, tx_full, tx_empty, tx_overflow
    );

    modport slave (
        input  tx_start, tx_data_in, parity_mode, stop2,
        output tx_data_out, tx_busy, tx_full, tx_empty, tx_overflow
    );
endinterface

// File: rtl/uart_tx_param.sv
`timescale 1ns/1ps
// UART transmitter: FIFO-buffered words framed as start/data/[parity]/stop(s); start bit one clock after a push into an idle block.
// Backpressure: tx_full stops pushes; a push while full is dropped and flagged by a one-cycle tx_overflow.
module uart_tx_param #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input logic            clk,
    input logic            rst,
    uart_tx_param_if.slave bus
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(DATA_WIDTH);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] BAUD_ONE  = CNT_W'(1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_WIDTH - 1);
    localparam logic [BIT_W-1:0] BIT_ONE   = BIT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W+1)'(1);
    localparam logic [PTR_W:0]   CNT_FULL  = (PTR_W+1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP1,
        S_STOP2
    } state_t;

    // ---------------- transmit FIFO ----------------
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W:0]        count;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  push;
    logic                  pop;
    logic                  ovf_q;
    logic [DATA_WIDTH-1:0] head_dat;

    assign fifo_full  = (count == CNT_FULL);
    assign fifo_empty = (count == '0);
    // Full is judged on the registered count, so a same-cycle pop never rescues a push.
    assign push       = bus.tx_start & ~fifo_full;
    assign head_dat   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.tx_data_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push && !pop) begin
                count <= count + CNT_ONE;
            end else if (!push && pop) begin
                count <= count - CNT_ONE;
            end
            ovf_q <= bus.tx_start & fifo_full;
        end
    end

    // ---------------- frame FSM ----------------
    state_t                state_q;
    state_t                state_d;
    logic [CNT_W-1:0]      baud_q;
    logic [CNT_W-1:0]      baud_d;
    logic [BIT_W-1:0]      bit_q;
    logic [BIT_W-1:0]      bit_d;
    logic                  baud_done;
    logic                  frame_end;
    logic [DATA_WIDTH-1:0] frame_dat_q;
    logic                  par_en_q;
    logic                  par_bit_q;
    logic                  stop2_q;
    logic                  line_q;
    logic                  line_d;

    assign baud_done = (baud_q == BAUD_LAST);

    // State register plus the per-frame datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            baud_q      <= '0;
            bit_q       <= '0;
            line_q      <= 1'b1;
            frame_dat_q <= '0;
            par_en_q    <= 1'b0;
            par_bit_q   <= 1'b0;
            stop2_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            line_q  <= line_d;
            if (pop) begin
                frame_dat_q <= head_dat;
                par_en_q    <= (bus.parity_mode == 2'b01) || (bus.parity_mode == 2'b10);
                par_bit_q   <= (^head_dat) ^ (bus.parity_mode == 2'b10);
                stop2_q     <= bus.stop2;
            end
        end
    end

    // Next-state and counter logic.
    always_comb begin
        state_d   = state_q;
        pop       = 1'b0;
        frame_end = 1'b0;
        case (state_q)
            S_IDLE:   frame_end = 1'b1;
            S_START:  if (baud_done) state_d = S_DATA;
            S_DATA: begin
                if (baud_done && (bit_q == BIT_LAST)) begin
                    state_d = par_en_q ? S_PARITY : S_STOP1;
                end
            end
            S_PARITY: if (baud_done) state_d = S_STOP1;
            S_STOP1: begin
                if (baud_done) begin
                    if (stop2_q) state_d = S_STOP2;
                    else         frame_end = 1'b1;
                end
            end
            S_STOP2:  if (baud_done) frame_end = 1'b1;
            default:  state_d = S_IDLE;
        endcase

        // IDLE behaves as a permanent end-of-frame, so queued words start with no gap.
        if (frame_end) begin
            if (!fifo_empty) begin
                state_d = S_START;
                pop     = 1'b1;
            end else begin
                state_d = S_IDLE;
            end
        end

        if ((state_q == S_IDLE) || (state_d != state_q) || baud_done) begin
            baud_d = '0;
        end else begin
            baud_d = baud_q + BAUD_ONE;
        end

        if (state_q != S_DATA) begin
            bit_d = '0;
        end else if (baud_done) begin
            bit_d = bit_q + BIT_ONE;
        end else begin
            bit_d = bit_q;
        end
    end

    // Line value for the coming cycle, registered so the serial output is glitch-free.
    always_comb begin
        line_d = 1'b1;
        case (state_d)
            S_START:  line_d = 1'b0;
            S_DATA:   line_d = frame_dat_q[bit_d];
            S_PARITY: line_d = par_bit_q;
            default:  line_d = 1'b1;
        endcase
    end

    assign bus.tx_data_out = line_q;
    assign bus.tx_busy     = (state_q != S_IDLE);
    assign bus.tx_full     = fifo_full;
    assign bus.tx_empty    = fifo_empty;
    assign bus.tx_overflow = ovf_q;

endmodule

// File: tb/tb_uart_tx_param.sv
`timescale 1ns/1ps
// Bench for uart_tx_param: scoreboarded frames decoded from the serial line, FIFO and reset scenarios.
module tb_uart_tx_param;

    localparam int DW    = 8;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [7:0] d;
        logic [1:0] m;
        logic       s2;
    } ent_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_tx_param_if #(.DATA_WIDTH(DW)) ifc ();

    uart_tx_param #(
        .DATA_WIDTH  (DW),
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(ifc)
    );

    int   total = 0;
    int   bad   = 0;
    ent_t sb[$];

    logic [15:0] rx_bits;
    bit          rx_stable;
    bit          rx_busy_all;
    bit          rx_timeout;
    int          rx_wait;

    // Expected line bits of one frame, LSB = start bit; unused upper bits are idle-high.
    function automatic int build_frame(input ent_t e, output logic [15:0] b);
        int n;
        b = '1;
        b[0] = 1'b0;
        for (int i = 0; i < 8; i++) b[i+1] = e.d[i];
        n = 9;
        if (e.m == 2'b01) begin
            b[n] = ^e.d;
            n++;
        end else if (e.m == 2'b10) begin
            b[n] = ~^e.d;
            n++;
        end
        b[n] = 1'b1;
        n++;
        if (e.s2) begin
            b[n] = 1'b1;
            n++;
        end
        return n;
    endfunction

    task automatic push(input logic [7:0] d);
        ifc.tx_data_in = d;
        ifc.tx_start   = 1'b1;
        @(posedge clk);
        #1;
        ifc.tx_start   = 1'b0;
    endtask

    // Wait (bounded) for a start bit, then sample every clock of nbits bit-times on the falling edge.
    task automatic rx_frame(input int nbits);
        rx_bits     = '1;
        rx_stable   = 1'b1;
        rx_busy_all = 1'b1;
        rx_timeout  = 1'b0;
        rx_wait     = 0;
        while (ifc.tx_data_out !== 1'b0 && rx_wait < 400) begin
            @(negedge clk);
            rx_wait++;
        end
        if (rx_wait >= 400) begin
            rx_timeout = 1'b1;
            return;
        end
        for (int i = 0; i < nbits; i++) begin
            for (int j = 0; j < CPB; j++) begin
                if (j == 0) rx_bits[i] = ifc.tx_data_out;
                else if (ifc.tx_data_out !== rx_bits[i]) rx_stable = 1'b0;
                if (ifc.tx_busy !== 1'b1) rx_busy_all = 1'b0;
                @(negedge clk);
            end
        end
    endtask

    task automatic test_reset();
        int viol;
        ifc.tx_start    = 1'b0;
        ifc.tx_data_in  = '0;
        ifc.parity_mode = 2'b00;
        ifc.stop2       = 1'b0;
        rst = 1'b0;
        #1 rst = 1'b1;
        #1;
        total++; if (ifc.tx_data_out !== 1'b1) begin bad++; $display("FAIL rst_line: got %b want 1", ifc.tx_data_out); end
        total++; if (ifc.tx_busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", ifc.tx_busy); end
        total++; if (ifc.tx_empty !== 1'b1) begin bad++; $display("FAIL rst_empty: got %b want 1", ifc.tx_empty); end
        total++; if (ifc.tx_full !== 1'b0) begin bad++; $display("FAIL rst_full: got %b want 0", ifc.tx_full); end
        total++; if (ifc.tx_overflow !== 1'b0) begin bad++; $display("FAIL rst_ovf: got %b want 0", ifc.tx_overflow); end
        @(negedge clk);
        rst = 1'b0;
        viol = 0;
        repeat (20) begin
            @(negedge clk);
            if (ifc.tx_data_out !== 1'b1 || ifc.tx_busy !== 1'b0 ||
                ifc.tx_empty !== 1'b1 || ifc.tx_overflow !== 1'b0) viol++;
        end
        total++; if (viol !== 0) begin bad++; $display("FAIL idle_quiet: got %0d bad cycles want 0", viol); end
    endtask

    task automatic test_frames();
        ent_t        tbl[4];
        ent_t        e;
        logic [15:0] exp;
        int          n;
        tbl[0] = {8'hA5, 2'b01, 1'b0};
        tbl[1] = {8'hA5, 2'b10, 1'b1};
        tbl[2] = {8'hA5, 2'b00, 1'b0};
        tbl[3] = {8'h3C, 2'b11, 1'b1};
        for (int k = 0; k < 4; k++) begin
            ifc.parity_mode = tbl[k].m;
            ifc.stop2       = tbl[k].s2;
            sb.push_back(tbl[k]);
            push(tbl[k].d);
            total++;
            if (ifc.tx_empty !== 1'b0 || ifc.tx_busy !== 1'b0) begin
                bad++; $display("FAIL push_latency[%0d]: got empty=%b busy=%b want 0 0", k, ifc.tx_empty, ifc.tx_busy);
            end
            e = sb.pop_front();
            n = build_frame(e, exp);
            rx_frame(n);
            total++;
            if (rx_timeout || rx_bits !== exp) begin bad++; $display("FAIL frame_bits[%0d]: got %h want %h", k, rx_bits, exp); end
            total++;
            if (rx_stable !== 1'b1 || rx_busy_all !== 1'b1) begin
                bad++; $display("FAIL frame_timing[%0d]: got stable=%b busy=%b want 1 1", k, rx_stable, rx_busy_all);
            end
            total++;
            if (ifc.tx_busy !== 1'b0) begin bad++; $display("FAIL frame_len[%0d]: busy after frame got %b want 0", k, ifc.tx_busy); end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] w[6];
        w[0] = 8'h11; w[1] = 8'h82; w[2] = 8'h33; w[3] = 8'hC4; w[4] = 8'h55; w[5] = 8'h66;
        ifc.parity_mode = 2'b01;
        ifc.stop2       = 1'b0;
        for (int i = 0; i < 5; i++) sb.push_back({w[i], 2'b01, 1'b0});
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    push(w[i]);
                    if (i == 1) begin
                        total++;
                        if (ifc.tx_data_out !== 1'b0 || ifc.tx_busy !== 1'b1) begin
                            bad++; $display("FAIL first_pop: got line=%b busy=%b want 0 1", ifc.tx_data_out, ifc.tx_busy);
                        end
                    end
                    if (i == 3) begin
                        total++; if (ifc.tx_full !== 1'b0) begin bad++; $display("FAIL full_early: got %b want 0", ifc.tx_full); end
                    end
                    if (i == 4) begin
                        total++; if (ifc.tx_full !== 1'b1) begin bad++; $display("FAIL full_set: got %b want 1", ifc.tx_full); end
                    end
                    if (i == 5) begin
                        total++;
                        if (ifc.tx_overflow !== 1'b1 || ifc.tx_full !== 1'b1) begin
                            bad++; $display("FAIL overflow: got ovf=%b full=%b want 1 1", ifc.tx_overflow, ifc.tx_full);
                        end
                    end
                end
                @(posedge clk);
                #1;
                total++; if (ifc.tx_overflow !== 1'b0) begin bad++; $display("FAIL ovf_pulse: got %b want 0", ifc.tx_overflow); end
            end
            begin
                ent_t        e;
                logic [15:0] exp;
                int          n;
                for (int k = 0; k < 5; k++) begin
                    e = sb.pop_front();
                    n = build_frame(e, exp);
                    rx_frame(n);
                    total++;
                    if (rx_timeout || rx_bits !== exp) begin bad++; $display("FAIL b2b_bits[%0d]: got %h want %h", k, rx_bits, exp); end
                    total++;
                    if (rx_stable !== 1'b1 || rx_busy_all !== 1'b1) begin
                        bad++; $display("FAIL b2b_timing[%0d]: got stable=%b busy=%b want 1 1", k, rx_stable, rx_busy_all);
                    end
                    if (k > 0) begin
                        total++; if (rx_wait !== 0) begin bad++; $display("FAIL b2b_gap[%0d]: got %0d idle clocks want 0", k, rx_wait); end
                    end
                end
                total++;
                if (ifc.tx_busy !== 1'b0 || ifc.tx_empty !== 1'b1) begin
                    bad++; $display("FAIL b2b_drained: got busy=%b empty=%b want 0 1", ifc.tx_busy, ifc.tx_empty);
                end
            end
        join
    endtask

    task automatic test_cfg_midframe();
        ifc.parity_mode = 2'b01;
        ifc.stop2       = 1'b0;
        sb.push_back({8'h3C, 2'b01, 1'b0});
        sb.push_back({8'h5A, 2'b10, 1'b1});
        fork
            begin
                push(8'h3C);
                push(8'h5A);
                repeat (6) @(posedge clk);
                #1;
                ifc.parity_mode = 2'b10;
                ifc.stop2       = 1'b1;
                repeat (50) @(posedge clk);
                #1;
                ifc.parity_mode = 2'b00;
                ifc.stop2       = 1'b0;
            end
            begin
                ent_t        e;
                logic [15:0] exp;
                int          n;
                for (int k = 0; k < 2; k++) begin
                    e = sb.pop_front();
                    n = build_frame(e, exp);
                    rx_frame(n);
                    total++;
                    if (rx_timeout || rx_bits !== exp) begin bad++; $display("FAIL cfg_bits[%0d]: got %h want %h", k, rx_bits, exp); end
                    total++;
                    if (rx_stable !== 1'b1 || rx_busy_all !== 1'b1) begin
                        bad++; $display("FAIL cfg_timing[%0d]: got stable=%b busy=%b want 1 1", k, rx_stable, rx_busy_all);
                    end
                end
            end
        join
    endtask

    task automatic test_reset_midframe();
        ent_t        e;
        logic [15:0] exp;
        int          n;
        int          viol;
        ifc.parity_mode = 2'b00;
        ifc.stop2       = 1'b0;
        push(8'hF0);
        push(8'h00);
        push(8'h0F);
        repeat (50) @(posedge clk);
        #2;
        total++;
        if (ifc.tx_busy !== 1'b1 || ifc.tx_data_out !== 1'b0 || ifc.tx_empty !== 1'b0) begin
            bad++; $display("FAIL pre_rst: got busy=%b line=%b empty=%b want 1 0 0", ifc.tx_busy, ifc.tx_data_out, ifc.tx_empty);
        end
        rst = 1'b1;
        #1;
        total++; if (ifc.tx_data_out !== 1'b1) begin bad++; $display("FAIL midrst_line: got %b want 1", ifc.tx_data_out); end
        total++; if (ifc.tx_empty !== 1'b1) begin bad++; $display("FAIL midrst_empty: got %b want 1", ifc.tx_empty); end
        total++; if (ifc.tx_busy !== 1'b0) begin bad++; $display("FAIL midrst_busy: got %b want 0", ifc.tx_busy); end
        @(negedge clk);
        rst = 1'b0;
        viol = 0;
        repeat (100) begin
            @(negedge clk);
            if (ifc.tx_data_out !== 1'b1 || ifc.tx_busy !== 1'b0 || ifc.tx_empty !== 1'b1) viol++;
        end
        total++; if (viol !== 0) begin bad++; $display("FAIL post_rst_quiet: got %0d bad cycles want 0", viol); end

        ifc.parity_mode = 2'b01;
        sb.push_back({8'hC3, 2'b01, 1'b0});
        push(8'hC3);
        e = sb.pop_front();
        n = build_frame(e, exp);
        rx_frame(n);
        total++;
        if (rx_timeout || rx_bits !== exp) begin bad++; $display("FAIL recover_bits: got %h want %h", rx_bits, exp); end
        total++;
        if (rx_stable !== 1'b1 || rx_busy_all !== 1'b1 || ifc.tx_busy !== 1'b0) begin
            bad++; $display("FAIL recover_timing: got stable=%b busy=%b end_busy=%b want 1 1 0", rx_stable, rx_busy_all, ifc.tx_busy);
        end
    endtask

    initial begin
        test_reset();
        test_frames();
        test_back_to_back();
        test_cfg_midframe();
        test_reset_midframe();
        total++;
        if (sb.size() !== 0) begin bad++; $display("FAIL scoreboard_left: got %0d entries want 0", sb.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish want finish before 500000ns");
        $fatal(1);
    end

endmodule

// File: doc/uart_tx_param.md
# uart_tx_param

Parametrised UART transmitter: a small transmit FIFO buffers words, and a baud-rate state machine serialises them. Frame shape is configurable: data width at build time, parity (none/even/odd) and 1 or 2 stop bits at run time. It is the next-generation replacement for the fixed 8-bit mux/PISO/parity transmitter path. It sits between the host write interface and the serial line.

## Interface
Parameters:
- DATA_WIDTH, 8: data bits per frame, legal 5–9.
- CLKS_PER_BIT, 16: clocks per serial bit, legal ≥ 2.
- FIFO_DEPTH, 4: transmit FIFO entries, power of two, legal ≥ 2.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- tx_start  input  1  write strobe; pushes tx_data_in when tx_full is low.
- tx_data_in  input  DATA_WIDTH  word to transmit.
- parity_mode  input  2  00 none, 01 even, 10 odd, 11 treated as none.
- stop2  input  1  0 = one stop bit, 1 = two stop bits.
- tx_data_out  output  1  serial line, registered, idle high.
- tx_busy  output  1  high while a frame is on the line.
- tx_full  output  1  FIFO holds FIFO_DEPTH words.
- tx_empty  output  1  FIFO holds zero words.
- tx_overflow  output  1  one-cycle pulse when tx_start is asserted while tx_full is high.

## Operation
- FIFO: circular buffer with read/write pointers and a count of width clog2(FIFO_DEPTH)+1; pointers wrap modulo FIFO_DEPTH.
- Push rule: tx_start=1 and tx_full=0 writes the word. If tx_full=1, the word is dropped, tx_overflow pulses, and FIFO contents are unchanged. A push while full is rejected even if a pop occurs in the same cycle.
- Simultaneous push and pop on a non-full FIFO: count is unchanged and both pointers advance.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2.
  - IDLE: if FIFO non-empty, pop the head into the shift register, latch parity_mode and stop2, go to START.
  - START: drive 0 for CLKS_PER_BIT clocks, then go to DATA.
  - DATA: drive the shift register LSB first, one bit per CLKS_PER_BIT clocks, for DATA_WIDTH bits. Then go to PARITY if the latched mode is even or odd, else STOP1.
  - PARITY: even drives XOR of all data bits; odd drives its inverse. One bit time.
  - STOP1: drive 1 for one bit time. Then go to STOP2 if stop2 was latched, else to end of frame.
  - STOP2: drive 1 for one bit time, then go to end of frame.
  - End of frame: if FIFO non-empty, pop and go directly to START (no idle gap); else go to IDLE.
- Config changes mid-frame have no effect until the next frame starts.
- Baud counter: counts 0..CLKS_PER_BIT-1, reloads at 0 on every state change. Bit index counts 0..DATA_WIDTH-1.

## Timing
- Reset values (asynchronous, immediate): tx_data_out=1, tx_busy=0, tx_empty=1, tx_full=0, tx_overflow=0. FSM goes to IDLE, pointers, count and counters clear.
- Reset mid-frame: the line returns high at once, the frame is abandoned, and FIFO contents are lost.
- Push latency: tx_start sampled at edge E0 updates tx_empty/tx_full after E0.
  - If the FSM is IDLE, it pops at E1; tx_data_out=0 and tx_busy=1 from E1.
- Frame length in clocks: CLKS_PER_BIT × (1 + DATA_WIDTH + P + S), where P ∈ {0,1} and S ∈ {1,2}.
- tx_busy falls at the edge where the FSM enters IDLE; it stays high across back-to-back frames.
- tx_full/tx_empty reflect the registered count; they update the same edge as the push or pop.

## Test plan
- Reset then idle: 20 clocks with no stimulus -> tx_data_out=1, tx_busy=0, tx_empty=1, tx_overflow never pulses.
- CLKS_PER_BIT=4, DATA_WIDTH=8, push 8'hA5, parity_mode=01, stop2=0 -> line 0, 1,0,1,0,0,1,0,1, parity 0, stop 1, each bit 4 clocks. Total 44 clocks; tx_busy high for exactly 44 clocks.
- Same word with parity_mode=10, stop2=1 -> parity bit 1, two stop bits, 48 clocks. Then parity_mode=00 -> no parity bit, 40 clocks.
- FIFO_DEPTH=4: push 5 words back-to-back while idle.
  - Check: first word popped at E1, tx_full asserts after the fifth push attempt's predecessor sequence, fifth push (if full) pulses tx_overflow.
  - Check: the remaining frames transmit back-to-back with no high gap between last stop and next start.
- Change parity_mode/stop2 mid-frame -> current frame unaffected, next frame uses new settings.
- Assert rst during DATA of frame 2 of 3 -> tx_data_out=1 immediately, tx_empty=1. No further frames until a new push.
